// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake and an architectural NZCV register.
// Stage 1 holds the operands and computes the result; stage 2 holds the result for writeback.
module alu_pipe #(
    parameter int         WIDTH       = 32,
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [3:0]       cmd,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             wr_en,
    output logic [3:0]       res_flags,
    output logic [3:0]       flags
);

    localparam logic [1:0] OP_DP  = 2'd0;
    localparam logic [1:0] OP_MEM = 2'd1;
    localparam logic [1:0] OP_BR  = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    localparam logic [3:0] C_AND = 4'b0000, C_EOR = 4'b0001, C_SUB = 4'b0010, C_RSB = 4'b0011;
    localparam logic [3:0] C_ADD = 4'b0100, C_ADC = 4'b0101, C_SBC = 4'b0110, C_RSC = 4'b0111;
    localparam logic [3:0] C_TST = 4'b1000, C_TEQ = 4'b1001, C_CMP = 4'b1010, C_CMN = 4'b1011;
    localparam logic [3:0] C_ORR = 4'b1100, C_MOV = 4'b1101, C_BIC = 4'b1110, C_MVN = 4'b1111;

    typedef struct packed {
        logic [1:0]       op;
        logic [3:0]       cmd;
        logic             set_flags;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             wr_en;
        logic [3:0]       nzcv;
    } rsp_t;

    req_t s1;
    req_t req_in;
    logic s1_valid;
    rsp_t rsp;

    logic stall, accept, advance;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~(s1_valid & stall);
    assign accept   = in_valid & in_ready;
    assign advance  = s1_valid & ~stall;

    assign req_in = '{op: op, cmd: cmd, set_flags: set_flags, a: a, b: b};

    // Every arithmetic op reduces to x + y + cin; logic ops bypass the adder
    // and carry C/V through from the architectural register.
    logic [WIDTH-1:0] x, y, logic_res, res;
    logic [WIDTH:0]   sum;
    logic             cin, arith, wr, c_out, v_out;

    always_comb begin
        x         = s1.a;
        y         = s1.b;
        cin       = 1'b0;
        arith     = 1'b1;
        logic_res = '0;
        wr        = 1'b1;
        case (s1.op)
            OP_DP: begin
                case (s1.cmd)
                    C_AND: begin arith = 1'b0; logic_res = s1.a & s1.b; end
                    C_EOR: begin arith = 1'b0; logic_res = s1.a ^ s1.b; end
                    C_SUB: begin y = ~s1.b; cin = 1'b1; end
                    C_RSB: begin x = s1.b; y = ~s1.a; cin = 1'b1; end
                    C_ADD: ;
                    C_ADC: cin = flags[1];
                    C_SBC: begin y = ~s1.b; cin = flags[1]; end
                    C_RSC: begin x = s1.b; y = ~s1.a; cin = flags[1]; end
                    C_TST: begin arith = 1'b0; logic_res = s1.a & s1.b; wr = 1'b0; end
                    C_TEQ: begin arith = 1'b0; logic_res = s1.a ^ s1.b; wr = 1'b0; end
                    C_CMP: begin y = ~s1.b; cin = 1'b1; wr = 1'b0; end
                    C_CMN: wr = 1'b0;
                    C_ORR: begin arith = 1'b0; logic_res = s1.a | s1.b; end
                    C_MOV: begin arith = 1'b0; logic_res = s1.b; end
                    C_BIC: begin arith = 1'b0; logic_res = s1.a & ~s1.b; end
                    C_MVN: begin arith = 1'b0; logic_res = ~s1.b; end
                    default: ;
                endcase
            end
            OP_MEM: y = s1.cmd[3] ? s1.b : '0;
            OP_BR:  ;
            OP_RSV: begin arith = 1'b0; logic_res = '0; wr = 1'b0; end
            default: ;
        endcase
    end

    assign sum   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    assign res   = arith ? sum[WIDTH-1:0] : logic_res;
    assign c_out = arith ? sum[WIDTH] : flags[1];
    assign v_out = arith ? ((x[WIDTH-1] == y[WIDTH-1]) && (res[WIDTH-1] != x[WIDTH-1])) : flags[0];

    assign rsp.result = res;
    assign rsp.wr_en  = wr;
    assign rsp.nzcv   = {res[WIDTH-1], (res == '0), c_out, v_out};

    // Flags commit as the op leaves stage 1, so a carry consumer that reaches
    // stage 1 always sees every older op already folded into flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1        <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            wr_en     <= 1'b0;
            res_flags <= 4'b0000;
            flags     <= FLAGS_RESET;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1       <= req_in;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end
            if (!stall)
                out_valid <= s1_valid;
            if (advance) begin
                result    <= rsp.result;
                wr_en     <= rsp.wr_en;
                res_flags <= rsp.nzcv;
                if (s1.op == OP_DP && s1.set_flags)
                    flags <= rsp.nzcv;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push expectations, a negedge monitor checks outputs.
module tb_alu_pipe;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [3:0]    cmd;
    logic          set_flags;
    logic [W-1:0]  a, b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          wr_en;
    logic [3:0]    res_flags;
    logic [3:0]    flags;

    alu_pipe #(.WIDTH(W), .FLAGS_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .cmd(cmd), .set_flags(set_flags), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .wr_en(wr_en), .res_flags(res_flags), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         wr;
        logic [3:0]   rf;
        logic [3:0]   fl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    bit   mon_en = 1'b0;

    // Front of the queue is compared every cycle the DUT shows a result,
    // so held-while-stalled outputs are checked too; popped only on handshake.
    always @(negedge clk) begin
        if (mon_en && !reset && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got res=%h wr=%b rf=%b need none", result, wr_en, res_flags);
            end else begin
                if (result !== exp_q[0].res || wr_en !== exp_q[0].wr ||
                    res_flags !== exp_q[0].rf || flags !== exp_q[0].fl) begin
                    errors++;
                    $display("FAIL %s got res=%h wr=%b rf=%b fl=%b need res=%h wr=%b rf=%b fl=%b",
                             exp_q[0].name, result, wr_en, res_flags, flags,
                             exp_q[0].res, exp_q[0].wr, exp_q[0].rf, exp_q[0].fl);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] need);
        checks++;
        if (got !== need) begin
            errors++;
            $display("FAIL %s got %h need %h", nm, got, need);
        end
    endtask

    task automatic issue(input string nm, input logic [1:0] o, input logic [3:0] c, input logic sf,
                         input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] er, input logic ew, input logic [3:0] erf,
                         input logic [3:0] efl, input bit push);
        int n;
        in_valid = 1'b1; op = o; cmd = c; set_flags = sf; a = ia; b = ib;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout got in_ready=0 need 1", nm);
        end else if (push) begin
            exp_q.push_back('{nm, er, ew, erf, efl});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cnt++;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(nm, W'(exp_q.size()), '0);
    endtask

    initial begin
        int base, n;
        reset = 1'b1; in_valid = 1'b0; op = '0; cmd = '0; set_flags = 1'b0;
        a = '0; b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_result", result, '0);
        check("rst_wr_en", W'(wr_en), '0);
        check("rst_res_flags", W'(res_flags), '0);
        check("rst_flags", W'(flags), '0);
        check("rst_in_ready", W'(in_ready), 1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // name, op, cmd, sf, a, b, result, wr_en, res_flags, flags-after, push
        issue("add_7_5",   0, 4'b0100, 1, 32'd7,        32'd5,        32'd12,       1, 4'b0000, 4'b0000, 1);
        issue("cmp_3_5",   0, 4'b1010, 1, 32'd3,        32'd5,        32'hFFFFFFFE, 0, 4'b1000, 4'b1000, 1);
        issue("sub_5_5",   0, 4'b0010, 1, 32'd5,        32'd5,        32'd0,        1, 4'b0110, 4'b0110, 1);
        issue("add_ovf",   0, 4'b0100, 1, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1, 4'b1001, 4'b1001, 1);
        issue("add_wrap",  0, 4'b0100, 1, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 4'b0110, 4'b0110, 1);
        issue("adc_b2b",   0, 4'b0101, 0, 32'd0,        32'd0,        32'd1,        1, 4'b0000, 4'b0110, 1);
        issue("cmp_clr_c", 0, 4'b1010, 1, 32'd3,        32'd5,        32'hFFFFFFFE, 0, 4'b1000, 4'b1000, 1);
        issue("sbc_c0",    0, 4'b0110, 0, 32'd5,        32'd3,        32'd1,        1, 4'b0010, 4'b1000, 1);
        issue("rsc_c0",    0, 4'b0111, 1, 32'd3,        32'd5,        32'd1,        1, 4'b0010, 4'b0010, 1);
        issue("and",       0, 4'b0000, 1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 4'b1010, 4'b1010, 1);
        issue("eor_zero",  0, 4'b0001, 1, 32'hFFFF0000, 32'hFFFF0000, 32'd0,        1, 4'b0110, 4'b0110, 1);
        issue("tst",       0, 4'b1000, 1, 32'h0F,       32'hF0,       32'd0,        0, 4'b0110, 4'b0110, 1);
        issue("orr_nosf",  0, 4'b1100, 0, 32'd1,        32'd2,        32'd3,        1, 4'b0010, 4'b0110, 1);
        issue("mov",       0, 4'b1101, 1, 32'd9,        32'h80000000, 32'h80000000, 1, 4'b1010, 4'b1010, 1);
        issue("mvn",       0, 4'b1111, 1, 32'd9,        32'd0,        32'hFFFFFFFF, 1, 4'b1010, 4'b1010, 1);
        issue("bic",       0, 4'b1110, 0, 32'hFF,       32'h0F,       32'hF0,       1, 4'b0010, 4'b1010, 1);
        issue("rsb",       0, 4'b0011, 1, 32'd3,        32'd10,       32'd7,        1, 4'b0010, 4'b0010, 1);
        issue("cmn",       0, 4'b1011, 1, 32'hFFFFFFFF, 32'd1,        32'd0,        0, 4'b0110, 4'b0110, 1);
        issue("mem_add",   1, 4'b1000, 1, 32'h100,      32'h8,        32'h108,      1, 4'b0000, 4'b0110, 1);
        issue("mem_base",  1, 4'b0000, 1, 32'h200,      32'h8,        32'h200,      1, 4'b0000, 4'b0110, 1);
        issue("branch",    2, 4'b0000, 1, 32'h1000,     32'hFFFFFFFC, 32'hFFC,      1, 4'b0010, 4'b0110, 1);
        issue("op3",       3, 4'b0100, 1, 32'd5,        32'd5,        32'd0,        0, 4'b0110, 4'b0110, 1);
        issue("sub_ovf",   0, 4'b0010, 1, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1, 4'b0011, 4'b0011, 1);
        drain("drain_directed");

        // Backpressure: consumer stalls while four ops stream in.
        @(posedge clk);
        #1 out_ready = 1'b0;
        base = acc_cnt;
        fork
            begin
                issue("stall_a", 0, 4'b0100, 0, 32'd1, 32'd1, 32'd2, 1, 4'b0000, 4'b0011, 1);
                issue("stall_b", 0, 4'b0100, 0, 32'd2, 32'd2, 32'd4, 1, 4'b0000, 4'b0011, 1);
                issue("stall_c", 0, 4'b0001, 0, 32'd3, 32'd3, 32'd0, 1, 4'b0111, 4'b0011, 1);
                issue("stall_d", 0, 4'b1100, 0, 32'd8, 32'd0, 32'd8, 1, 4'b0011, 4'b0011, 1);
            end
            begin
                n = 0;
                while (acc_cnt < base + 2 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("stall_in_ready", W'(in_ready), '0);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_stall");

        // Reset with two set_flags ops in flight: both must vanish.
        mon_en = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue("inflight_1", 0, 4'b0100, 1, 32'h7FFFFFFF, 32'd1, 32'h0, 1, 4'b0000, 4'b0000, 0);
        issue("inflight_2", 0, 4'b0100, 1, 32'hFFFFFFFF, 32'd1, 32'h0, 1, 4'b0000, 4'b0000, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst2_out_valid", W'(out_valid), '0);
        check("rst2_flags", W'(flags), '0);
        check("rst2_in_ready", W'(in_ready), 1);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst2_no_out", W'(out_valid), '0);
            check("rst2_no_commit", W'(flags), '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational datapath ALU.
- Executes data-processing, memory-address and branch-target operations at WIDTH bits, using the same op/cmd encoding as the existing ALU.
- Adds a valid/ready handshake, a 2-stage pipeline with backpressure, an architectural NZCV flags register with conditional update, and carry-consuming ops (ADC/SBC).
- Sits between decode/register-read and writeback in the multi-cycle core.

Parameters:
- WIDTH, 32, datapath width in bits (>= 4).
- FLAGS_RESET, 4'b0000, reset value of the NZCV register.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  stage 1 can accept this cycle.
- op  input  2  0 data-proc, 1 memory, 2 branch, 3 reserved.
- cmd  input  4  operation code, see Behaviour.
- set_flags  input  1  update NZCV when this op retires from stage 1.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result held in stage 2.
- out_ready  input  1  consumer accepts the stage-2 result.
- result  output  WIDTH  stage-2 result.
- wr_en  output  1  result is to be written back; 0 for compare/test ops and op 3.
- res_flags  output  4  NZCV computed for this result, valid even when not committed.
- flags  output  4  architectural NZCV register, bit 3 = N, bit 0 = V.

Behaviour:
- Reset:
  - s1_valid = 0, out_valid = 0, result = 0, wr_en = 0, res_flags = 0, flags = FLAGS_RESET.
  - Operations in flight are discarded.
  - in_ready is 1 in the cycle after reset deasserts.
- Handshake and pipeline:
  - Stall condition: `stall = out_valid & ~out_ready`.
  - in_ready = ~(s1_valid & stall).
  - An accept occurs when in_valid & in_ready; operands, op, cmd and set_flags are registered into stage 1.
  - Stage 1 advances to stage 2 when s1_valid & ~stall. Result, wr_en and res_flags are computed combinationally in stage 1 and registered into stage 2.
  - out_valid clears on `out_ready & ~(s1_valid)`.
  - Latency: accept at edge k gives out_valid at edge k+1 with no stall. Throughput is 1 operation per cycle.
  - Outputs are held stable while stalled.
- Flags commit:
  - flags updates on the edge where stage 1 advances, only if op == 0 and set_flags == 1.
  - ADC, SBC and RSC read flags in stage 1. All older operations have already committed there, so no forwarding is needed.
- op 0, cmd:
  - 0000 AND: A&B
  - 0001 EOR: A^B
  - 0010 SUB: A-B
  - 0011 RSB: B-A
  - 0100 ADD: A+B
  - 0101 ADC: A+B+C
  - 0110 SBC: A-B-1+C
  - 0111 RSC: B-A-1+C
  - 1000 TST: A&B, wr_en = 0
  - 1001 TEQ: A^B, wr_en = 0
  - 1010 CMP: A-B, wr_en = 0
  - 1011 CMN: A+B, wr_en = 0
  - 1100 ORR: A|B
  - 1101 MOV: B
  - 1110 BIC: A&~B
  - 1111 MVN: ~B
- op 1: result = cmd[3] ? A+B : A, wr_en = 1, flags never updated.
- op 2: result = A+B, wr_en = 1, flags never updated.
- op 3: result = 0, wr_en = 0, flags never updated.
- Arithmetic:
  - All ops are computed as X + Y + cin in WIDTH+1 bits.
  - Subtraction is X + ~Y + 1 (SBC/RSC: cin = C).
  - C is the carry-out bit WIDTH. For subtraction C = 1 means no borrow, so 5-3 gives C = 1 and 3-5 gives C = 0.
  - V = (X[W-1] == Y'[W-1]) & (R[W-1] != X[W-1]), where Y' is the inverted operand for subtraction.
  - Logic ops and MOV/MVN: C and V keep the current flags[1:0] values.
  - N = R[W-1]; Z = (R == 0). Both apply to every op.
- Simultaneous events:
  - Accept and stage-1 advance in the same cycle is legal, and the new op replaces the old one.
  - reset has priority over every handshake.

Test Plan:
- WIDTH=32, reset then ADD a=7 b=5 set_flags=1, out_ready=1 -> out_valid 1 cycle after accept, result=12, wr_en=1, flags=0000.
- CMP a=3 b=5 set_flags=1 -> wr_en=0, res_flags=N1 Z0 C0 V0, flags=1000. Then SUB a=5 b=5 set_flags=1 -> result=0, flags=0110.
- ADD a=0x7FFFFFFF b=1 set_flags=1 -> result=0x80000000, flags=1001. ADD a=0xFFFFFFFF b=1 set_flags=1 -> result=0, flags=0110.
- ADD a=0xFFFFFFFF b=1 set_flags=1, then ADC a=0 b=0 issued back-to-back -> ADC result=1 (forward-free carry from the prior op).
- Stream 4 ops with out_ready held low 3 cycles -> in_ready drops after 2 accepts, results emerge in order and are unchanged while stalled, and no op is lost or duplicated.
- Assert reset with 2 ops in flight and set_flags=1 -> next cycle out_valid=0, flags=FLAGS_RESET, and no spurious flag commit occurs.
